uart_sensor_dispatcher: RTL

//  Multi-channel command dispatcher between a byte-level UART RX/TX pair and N_CH DHT11-style sensor readers.

---
 rtl/uart_sensor_dispatcher.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_sensor_dispatcher.sv
// Two-byte UART command dispatcher (address, command) for N_CH DHT11-style sensor readers.
// Optional macro DHT_CHECKSUM_EN: verify the frame checksum and report code 0xFE on mismatch.
module uart_sensor_dispatcher #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned MEAS_W      = 40,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned GAP_CYC     = 20000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [N_CH-1:0]        sensor_start,
  input  logic [N_CH-1:0]        sensor_done,
  input  logic [N_CH*MEAS_W-1:0] sensor_data,
  output logic                   busy
);
  localparam int unsigned TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [TW-1:0]   GAP_LAST = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      N_CH_B   = 8'(N_CH);
  localparam logic [N_CH-1:0] CH_ONE   = N_CH'(1);
  localparam logic [7:0]      CMD_PING = 8'h00;
  localparam logic [7:0]      CMD_TEMP = 8'h04;
  localparam logic [7:0]      CMD_HUM  = 8'h05;

  typedef enum logic [2:0] {IDLE, GET_CMD, DECODE, MEASURE, TX_CODE, TX_DATA} state_t;

  state_t          state, state_next;
  logic [7:0]      addr, addr_next, cmd, cmd_next, code, code_next, data, data_next;
  logic [7:0]      tx_data_next;
  logic [TW-1:0]   timer, timer_next, timer_inc;
  logic            sent, sent_next, tx_start_next;
  logic [N_CH-1:0] sensor_start_next;
  logic [CH_W-1:0] addr_idx;
  logic [MEAS_W-1:0] frame;

  assign addr_idx = addr[CH_W-1:0];
  assign frame    = sensor_data[32'(addr_idx) * MEAS_W +: MEAS_W];

`ifdef DHT_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
`else
  logic unused_frame;
  assign unused_frame = ^frame;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr         <= '0;
      cmd          <= '0;
      code         <= '0;
      data         <= '0;
      timer        <= '0;
      sent         <= 1'b0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      sensor_start <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      addr         <= addr_next;
      cmd          <= cmd_next;
      code         <= code_next;
      data         <= data_next;
      timer        <= timer_next;
      sent         <= sent_next;
      tx_data      <= tx_data_next;
      tx_start     <= tx_start_next;
      sensor_start <= sensor_start_next;
      busy         <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next        = state;
    addr_next         = addr;
    cmd_next          = cmd;
    code_next         = code;
    data_next         = data;
    timer_next        = timer;
    sent_next         = sent;
    tx_data_next      = tx_data;
    tx_start_next     = 1'b0;
    sensor_start_next = '0;
    timer_inc         = (timer == '1) ? timer : timer + TW'(1);

    case (state)
      IDLE: if (rx_valid) begin
        addr_next  = rx_data;
        timer_next = '0;
        state_next = GET_CMD;
      end
      GET_CMD: begin
        if (rx_valid) begin
          cmd_next   = rx_data;
          state_next = DECODE;
          // Registered pulse lands in the DECODE cycle
          if ((addr < N_CH_B) && ((rx_data == CMD_TEMP) || (rx_data == CMD_HUM)))
            sensor_start_next = CH_ONE << addr_idx;
        end else if (timer == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_inc;
        end
      end
      DECODE: begin
        if (addr >= N_CH_B) begin
          code_next  = 8'h0E;
          data_next  = addr;
          state_next = TX_CODE;
        end else if (cmd == CMD_PING) begin
          code_next  = 8'h07;
          data_next  = addr;
          state_next = TX_CODE;
        end else if ((cmd == CMD_TEMP) || (cmd == CMD_HUM)) begin
          timer_next = '0;
          state_next = MEASURE;
        end else begin
          code_next  = 8'h0F;
          data_next  = 8'h00;
          state_next = TX_CODE;
        end
      end
      MEASURE: begin
        if (sensor_done[addr_idx]) begin
          state_next = TX_CODE;
          if (cmd == CMD_TEMP) begin
            code_next = 8'h02;
            data_next = frame[23:16];
          end else begin
            code_next = 8'h01;
            data_next = frame[39:32];
          end
`ifdef DHT_CHECKSUM_EN
          if (csum != frame[7:0]) begin
            code_next = 8'hFE;
            data_next = csum;
          end
`endif
        end else if (timer == TO_LAST) begin
          code_next  = 8'hFF;
          data_next  = 8'h00;
          state_next = TX_CODE;
        end else begin
          timer_next = timer_inc;
        end
      end
      TX_CODE: if (sent && tx_done) begin
        sent_next  = 1'b0;
        state_next = TX_DATA;
      end
      TX_DATA: if (sent && tx_done) begin
        sent_next    = 1'b0;
        tx_data_next = '0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Launch each byte on the first cycle the transmitter is free, looking one state ahead
    if (((state_next == TX_CODE) || (state_next == TX_DATA)) && !sent_next && !tx_busy) begin
      tx_start_next = 1'b1;
      sent_next     = 1'b1;
      tx_data_next  = (state_next == TX_CODE) ? code_next : data_next;
    end
  end
endmodule
